scaler_chain: RTL and testbench

- Scaler that sits directly downstream of the timer block.
- Consumes FS01, the timer's first-stage divided square wave, and extends it into a binary divider chain FS02..FS(NST+1).
- Produces one-cycle rise/fall strobes per stage (FA/FB) for the alarm, standby and counter-interrupt logic.
- Also produces an atomic snapshot of the whole chain for software scaler-channel reads.

---
 rtl/scaler_chain.sv | 89 ++++++++
 tb/tb_scaler_chain.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/scaler_chain.sv
// Binary divider chain extending the timer's FS01 square wave into FS02..FS(NST+1),
// with per-stage rise/fall strobes, wrap strobe and a coherent snapshot register.
module scaler_chain #(
  parameter int NST = 32
) (
  input  logic           SIM_CLK,
  input  logic           SIM_RST,
  input  logic           FS01,
  input  logic           SCAEN,
  input  logic           SCACLR,
  input  logic           RDSCL,
  output logic [NST-1:0] FS,
  output logic [NST-1:0] FA,
  output logic [NST-1:0] FB,
  output logic           SCLOVF,
  output logic [NST-1:0] SNAP,
  output logic           SNAPVLD
);

  localparam logic [NST-1:0] CNT_ZERO = {NST{1'b0}};
  localparam logic [NST-1:0] CNT_ONE  = {{(NST-1){1'b0}}, 1'b1};

  logic           fs01_q;
  logic [NST-1:0] cnt;
  logic [NST-1:0] cnt_d;
  logic           ovf_q;
  logic [NST-1:0] snap;
  logic           vld_q;

  logic           fall;
  logic           inc;

  // FS01 falling edge qualified by the count enable
  always_comb begin
    fall = fs01_q & ~FS01;
    inc  = SCAEN & fall;
  end

  // Input sampler, divider chain, delayed copy and wrap flag
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      fs01_q <= 1'b0;
      cnt    <= CNT_ZERO;
      cnt_d  <= CNT_ZERO;
      ovf_q  <= 1'b0;
    end else begin
      fs01_q <= FS01;
      if (SCACLR) begin
        // Clearing both copies keeps the strobes quiet on a restart
        cnt   <= CNT_ZERO;
        cnt_d <= CNT_ZERO;
        ovf_q <= 1'b0;
      end else if (inc) begin
        cnt   <= cnt + CNT_ONE;
        cnt_d <= cnt;
        ovf_q <= &cnt;
      end else begin
        cnt   <= cnt;
        cnt_d <= cnt;
        ovf_q <= 1'b0;
      end
    end
  end

  // Snapshot captures the pre-update chain value in one register
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      snap  <= CNT_ZERO;
      vld_q <= 1'b0;
    end else if (RDSCL) begin
      snap  <= cnt;
      vld_q <= 1'b1;
    end else begin
      snap  <= snap;
      vld_q <= 1'b0;
    end
  end

  // Outputs derive only from registers
  always_comb begin
    FS      = cnt;
    FA      = cnt & ~cnt_d;
    FB      = ~cnt & cnt_d;
    SCLOVF  = ovf_q;
    SNAP    = snap;
    SNAPVLD = vld_q;
  end

endmodule

// File: tb/tb_scaler_chain.sv
// Self-checking bench for scaler_chain: a full-width instance plus a 4-stage
// instance on the same stimulus, checked against a scoreboard and directed values.
module tb_scaler_chain;

  logic        sim_clk = 1'b0;
  logic        sim_rst = 1'b0;
  logic        fs01    = 1'b0;
  logic        scaen   = 1'b0;
  logic        scaclr  = 1'b0;
  logic        rdscl   = 1'b0;

  logic [31:0] fs, fa, fb, snap;
  logic        sclovf, snapvld;
  logic [3:0]  fs4, fa4, fb4, snap4;
  logic        sclovf4, snapvld4;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] fs;
    logic [31:0] fa;
    logic [31:0] fb;
    logic [31:0] snap;
    logic        ovf;
    logic        vld;
    logic        ovf4;
  } exp_t;

  exp_t exp_q[$];

  // Reference state: what the chain should hold after each edge
  logic        m_fs01 = 1'b0;
  logic [31:0] m_cnt  = 32'd0;
  logic [31:0] m_snap = 32'd0;

  scaler_chain #(.NST(32)) dut (
    .SIM_CLK(sim_clk), .SIM_RST(sim_rst), .FS01(fs01), .SCAEN(scaen),
    .SCACLR(scaclr), .RDSCL(rdscl), .FS(fs), .FA(fa), .FB(fb),
    .SCLOVF(sclovf), .SNAP(snap), .SNAPVLD(snapvld)
  );

  scaler_chain #(.NST(4)) dut4 (
    .SIM_CLK(sim_clk), .SIM_RST(sim_rst), .FS01(fs01), .SCAEN(scaen),
    .SCACLR(scaclr), .RDSCL(rdscl), .FS(fs4), .FA(fa4), .FB(fb4),
    .SCLOVF(sclovf4), .SNAP(snap4), .SNAPVLD(snapvld4)
  );

  always #5 sim_clk = ~sim_clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Predict the outputs that follow the coming edge, then advance one cycle and compare
  task automatic step();
    exp_t        e;
    logic        f, up;
    logic [31:0] nxt;
    if (sim_rst) begin
      e = '{fs: 32'd0, fa: 32'd0, fb: 32'd0, snap: 32'd0, ovf: 1'b0, vld: 1'b0, ovf4: 1'b0};
      m_fs01 = 1'b0;
      m_cnt  = 32'd0;
      m_snap = 32'd0;
    end else begin
      f   = m_fs01 & ~fs01;
      up  = scaen & f & ~scaclr;
      nxt = scaclr ? 32'd0 : (up ? m_cnt + 32'd1 : m_cnt);
      e.fs   = nxt;
      e.fa   = scaclr ? 32'd0 : (nxt & ~m_cnt);
      e.fb   = scaclr ? 32'd0 : (~nxt & m_cnt);
      e.ovf  = up && (m_cnt == 32'hFFFF_FFFF);
      e.ovf4 = up && (m_cnt[3:0] == 4'hF);
      e.snap = rdscl ? m_cnt : m_snap;
      e.vld  = rdscl;
      m_fs01 = fs01;
      m_cnt  = nxt;
      m_snap = e.snap;
    end
    exp_q.push_back(e);
    @(posedge sim_clk);
    #1;
    if (exp_q.size() == 0) begin
      check_value("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_value("fs",       fs,                e.fs);
      check_value("fa",       fa,                e.fa);
      check_value("fb",       fb,                e.fb);
      check_value("sclovf",   {31'd0, sclovf},   {31'd0, e.ovf});
      check_value("snap",     snap,              e.snap);
      check_value("snapvld",  {31'd0, snapvld},  {31'd0, e.vld});
      check_value("fs4",      {28'd0, fs4},      {28'd0, e.fs[3:0]});
      check_value("fa4",      {28'd0, fa4},      {28'd0, e.fa[3:0]});
      check_value("fb4",      {28'd0, fb4},      {28'd0, e.fb[3:0]});
      check_value("sclovf4",  {31'd0, sclovf4},  {31'd0, e.ovf4});
      check_value("snap4",    {28'd0, snap4},    {28'd0, e.snap[3:0]});
      check_value("snapvld4", {31'd0, snapvld4}, {31'd0, e.vld});
    end
  endtask

  // One FS01 period of 8 cycles; the fall edge carries the optional side strobes
  task automatic do_fall(input logic clr, input logic rd, input logic rst);
    repeat (3) step();
    fs01 = 1'b1;
    repeat (4) step();
    fs01   = 1'b0;
    scaclr = clr;
    rdscl  = rd;
    sim_rst = rst;
    step();
    scaclr  = 1'b0;
    rdscl   = 1'b0;
    sim_rst = 1'b0;
  endtask

  initial begin
    // Reset
    sim_rst = 1'b1;
    step();
    step();
    sim_rst = 1'b0;
    check_value("rst_fs", fs, 32'd0);
    check_value("rst_vld", {31'd0, snapvld}, 32'd0);

    // Test 1: 16 falls at period 8
    scaen = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      do_fall(1'b0, 1'b0, 1'b0);
      check_value("t1_count", fs, i);
      if (i == 1 || i == 3 || i == 5) check_value("t1_fa0", fa, 32'h1);
      if (i == 2) begin
        check_value("t1_fa2", fa, 32'h2);
        check_value("t1_fb2", fb, 32'h1);
      end
    end
    check_value("t1_fa16", fa, 32'h10);
    check_value("t1_fb16", fb, 32'hF);
    check_value("t1_wrap4", {31'd0, sclovf4}, 32'd1);

    // Test 2: narrow chain from E through F to wrap
    for (int i = 0; i < 14; i++) do_fall(1'b0, 1'b0, 1'b0);
    check_value("t2_e", {28'd0, fs4}, 32'hE);
    do_fall(1'b0, 1'b0, 1'b0);
    check_value("t2_f", {28'd0, fs4}, 32'hF);
    do_fall(1'b0, 1'b0, 1'b0);
    check_value("t2_zero", {28'd0, fs4}, 32'h0);
    check_value("t2_ovf", {31'd0, sclovf4}, 32'd1);
    check_value("t2_fb", {28'd0, fb4}, 32'hF);
    check_value("t2_fa", {28'd0, fa4}, 32'h0);
    check_value("t2_wide", fs, 32'd32);
    step();
    check_value("t2_ovf_once", {31'd0, sclovf4}, 32'd0);

    // Test 3: FS01 high across reset release, then enable gating
    fs01 = 1'b1;
    sim_rst = 1'b1;
    step();
    sim_rst = 1'b0;
    repeat (4) step();
    check_value("t3_no_false_edge", fs, 32'd0);
    do_fall(1'b0, 1'b0, 1'b0);
    check_value("t3_first", fs, 32'd1);
    scaen = 1'b0;
    repeat (3) do_fall(1'b0, 1'b0, 1'b0);
    check_value("t3_gated", fs, 32'd1);
    scaen = 1'b1;
    do_fall(1'b0, 1'b0, 1'b0);
    check_value("t3_resume", fs, 32'd2);

    // Test 4: clear on the same edge as a fall
    repeat (3) do_fall(1'b0, 1'b0, 1'b0);
    check_value("t4_five", fs, 32'd5);
    do_fall(1'b1, 1'b0, 1'b0);
    check_value("t4_clr_fs", fs, 32'd0);
    check_value("t4_clr_fa", fa, 32'd0);
    check_value("t4_clr_fb", fb, 32'd0);
    check_value("t4_clr_ovf", {31'd0, sclovf}, 32'd0);
    do_fall(1'b0, 1'b0, 1'b0);
    check_value("t4_after_fs", fs, 32'd1);
    check_value("t4_after_fa", fa, 32'd1);

    // Test 5: snapshot coincident with increment, then back-to-back reads
    repeat (6) do_fall(1'b0, 1'b0, 1'b0);
    check_value("t5_seven", fs, 32'd7);
    do_fall(1'b0, 1'b1, 1'b0);
    check_value("t5_snap", snap, 32'd7);
    check_value("t5_vld", {31'd0, snapvld}, 32'd1);
    check_value("t5_fs", fs, 32'd8);
    step();
    check_value("t5_vld_once", {31'd0, snapvld}, 32'd0);
    rdscl = 1'b1;
    step();
    check_value("t5_b2b_1", {31'd0, snapvld}, 32'd1);
    step();
    rdscl = 1'b0;
    check_value("t5_b2b_2", {31'd0, snapvld}, 32'd1);
    check_value("t5_b2b_snap", snap, 32'd8);

    // Test 6: reset while FA pulses and RDSCL is high
    do_fall(1'b0, 1'b0, 1'b0);
    check_value("t6_nine", fs, 32'd9);
    check_value("t6_fa_pulse", fa, 32'd1);
    sim_rst = 1'b1;
    rdscl   = 1'b1;
    step();
    sim_rst = 1'b0;
    rdscl   = 1'b0;
    check_value("t6_fs", fs, 32'd0);
    check_value("t6_fa", fa, 32'd0);
    check_value("t6_fb", fb, 32'd0);
    check_value("t6_snap", snap, 32'd0);
    check_value("t6_vld", {31'd0, snapvld}, 32'd0);
    do_fall(1'b0, 1'b0, 1'b0);
    check_value("t6_resume", fs, 32'd1);

    check_value("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
